// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// Every output comes straight from a flop, so ready never ripples combinationally
// across stages. The register supports a synchronous flush and a programmable reset value.
//
// Optional feature: define PIPE_STAGE_XFILT_EN (simulation builds) to drop any
// accepted beat whose data carries X/Z bits. Such a beat also raises the sticky xerr flag.
// Without the macro, every accepted beat is stored and xerr is tied low.
module pipe_stage_reg #(
  parameter int unsigned  N         = 32,
  parameter logic [N-1:0] RESET_VAL = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   occupancy,
  output logic         xerr
);

  // State encoding doubles as the valid bits: bit 0 = main_valid, bit 1 = skid_valid.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;
  logic accept;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_q;
  // 00 -> 0, 01 -> 1, 11 -> 2; the unused 10 code never occurs.
  assign occupancy = {skid_valid, main_valid & ~skid_valid};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

`ifdef PIPE_STAGE_XFILT_EN
  logic xerr_q, xerr_d;
  logic x_beat;

  // Any X/Z bit in the data makes the reduction XOR unknown.
  always_comb begin
    x_beat = 1'b0;
    if ((^in_data) === 1'bx) begin
      x_beat = 1'b1;
    end
  end

  // An X-carrying beat is acknowledged upstream but never stored.
  assign accept = in_fire & ~x_beat;

  // The sticky error flag clears only on reset.
  always_comb begin
    xerr_d = xerr_q | (in_fire & x_beat);
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xerr_q <= 1'b0;
    end else begin
      xerr_q <= xerr_d;
    end
  end

  assign xerr = xerr_q;
`else
  assign accept = in_fire;
  assign xerr   = 1'b0;
`endif

  // Next-state and data-path selection; flush overrides all traffic.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          main_d  = in_data;
        end
      end
      StOne: begin
        if (accept && out_fire) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = StFull;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          state_d = StOne;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase

    // Flush kills held beats but leaves the data registers untouched.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // State and data registers; reset dominates flush and traffic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table plus hand-written sequences
// that cover ordered streaming under irregular backpressure and X filtering.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  occupancy;
  logic        xerr;

  logic        in_ready0;
  logic [31:0] out_data0;
  logic        out_valid0;
  logic [1:0]  occupancy0;
  logic        xerr0;

  int n_cmp;
  int n_bad;

  pipe_stage_reg #(
    .N(32)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .xerr     (xerr)
  );

  // Second copy with a zero reset value, fed the same stimulus.
  pipe_stage_reg #(
    .N        (32),
    .RESET_VAL(32'h0)
  ) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready0),
    .out_data (out_data0),
    .out_valid(out_valid0),
    .out_ready(out_ready),
    .occupancy(occupancy0),
    .xerr     (xerr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        chk_data;
    logic        exp_ready;
    logic [1:0]  exp_occ;
    logic        is_rst;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic ev, input logic [31:0] ed,
                              input logic cd, input logic er, input logic [1:0] eo);
    vec_t v;
    v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_data = ed; v.chk_data = cd; v.exp_ready = er; v.exp_occ = eo;
    v.is_rst = ~r;
    return v;
  endfunction

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    //                 rst flu iv data          ordy ev  exp_data      cd er occ
    // Reset, two cycles.
    vecs.push_back(mk(0, 0, 0, 32'h0,        0,   0, 32'hFFFFFFFF, 1, 1, 2'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0,   0, 32'hFFFFFFFF, 1, 1, 2'd0));
    // Streaming 1,2,3 with out_ready high.
    vecs.push_back(mk(1, 0, 1, 32'h1,        1,   1, 32'h1,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 1, 32'h2,        1,   1, 32'h2,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 1, 32'h3,        1,   1, 32'h3,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1,   0, 32'h0,        0, 1, 2'd0));
    // Backpressure: A, B fill; C waits upstream; then drain A, B, C.
    vecs.push_back(mk(1, 0, 1, 32'hA,        0,   1, 32'hA,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 1, 32'hB,        0,   1, 32'hA,        1, 0, 2'd2));
    vecs.push_back(mk(1, 0, 1, 32'hC,        0,   1, 32'hA,        1, 0, 2'd2));
    vecs.push_back(mk(1, 0, 1, 32'hC,        1,   1, 32'hB,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 1, 32'hC,        1,   1, 32'hC,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1,   0, 32'h0,        0, 1, 2'd0));
    // Flush while FULL with a competing beat D.
    vecs.push_back(mk(1, 0, 1, 32'hA,        0,   1, 32'hA,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 1, 32'hB,        0,   1, 32'hA,        1, 0, 2'd2));
    vecs.push_back(mk(1, 1, 1, 32'hD,        0,   0, 32'h0,        0, 1, 2'd0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1,   0, 32'h0,        0, 1, 2'd0));
    // Reset beats flush and traffic while FULL.
    vecs.push_back(mk(1, 0, 1, 32'hA,        0,   1, 32'hA,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 1, 32'hB,        0,   1, 32'hA,        1, 0, 2'd2));
    vecs.push_back(mk(0, 1, 1, 32'hD,        1,   0, 32'hFFFFFFFF, 1, 1, 2'd0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1,   0, 32'h0,        0, 1, 2'd0));
    // Flush during a drain, then a clean beat with no stale skid data.
    vecs.push_back(mk(1, 0, 1, 32'h5,        0,   1, 32'h5,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 1, 32'h6,        0,   1, 32'h5,        1, 0, 2'd2));
    vecs.push_back(mk(1, 1, 0, 32'h0,        1,   0, 32'h0,        0, 1, 2'd0));
    vecs.push_back(mk(1, 0, 1, 32'h7,        1,   1, 32'h7,        1, 1, 2'd1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1,   0, 32'h0,        0, 1, 2'd0));

    foreach (vecs[i]) begin
      rst_n     = vecs[i].rst_n;
      flush     = vecs[i].flush;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_ready});
      check($sformatf("v%0d occupancy", i), {30'b0, occupancy}, {30'b0, vecs[i].exp_occ});
      check($sformatf("v%0d xerr", i), {31'b0, xerr}, 32'h0);
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d out_data", i), out_data, vecs[i].exp_data);
      end
      if (vecs[i].is_rst) begin
        check($sformatf("v%0d rv0 out_data", i), out_data0, 32'h0);
        check($sformatf("v%0d rv0 occupancy", i), {30'b0, occupancy0}, 32'h0);
      end
    end

    // Ordered streaming under an irregular out_ready pattern.
    begin
      logic [15:0] pat;
      int          sent;
      int          rcvd;
      int          cyc;
      logic        fin;
      logic        fout;
      pat  = 16'b1011_0010_1100_1101;
      sent = 0;
      rcvd = 0;
      cyc  = 0;
      flush = 1'b0;
      while (rcvd < 10 && cyc < 200) begin
        in_valid  = (sent < 10);
        in_data   = 32'h100 + sent;
        out_ready = pat[cyc % 16];
        #1;
        fin  = in_valid & in_ready;
        fout = out_valid & out_ready;
        if (fout) begin
          check($sformatf("stream beat %0d", rcvd), out_data, 32'h100 + rcvd);
          rcvd++;
        end
        @(posedge clk);
        #1;
        if (fin) sent++;
        cyc++;
      end
      check("stream beats received", rcvd, 10);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stream drained occupancy", {30'b0, occupancy}, 32'h0);
    end

    // Sustained throughput: one beat per cycle with out_ready high.
    begin
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b1;
        in_data  = 32'h200 + k;
        @(posedge clk);
        #1;
        check($sformatf("tput data %0d", k), out_data, 32'h200 + k);
        check($sformatf("tput in_ready %0d", k), {31'b0, in_ready}, 32'h1);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end

`ifdef PIPE_STAGE_XFILT_EN
    // An X-carrying beat is dropped, and xerr stays set until reset.
    begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h0000_00X0;
      #1;
      check("xfilt in_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk);
      #1;
      check("xfilt dropped", {31'b0, out_valid}, 32'h0);
      check("xfilt xerr set", {31'b0, xerr}, 32'h1);
      in_data = 32'h5;
      @(posedge clk);
      #1;
      check("xfilt next data", out_data, 32'h5);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("xfilt xerr sticky", {31'b0, xerr}, 32'h1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("xfilt xerr cleared", {31'b0, xerr}, 32'h0);
    end
`else
    check("xerr tied low", {31'b0, xerr}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
